mem_stage: RTL and testbench

//  Memory-access stage; sits directly downstream of ex and consumes its outputs.
//  Non-memory ops pass through in one cycle. Loads and stores run a req/gnt/rvalid

---
 rtl/mem_stage.sv | 181 ++++++++++++++++++
 tb/tb_mem_stage.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: non-memory ops pass through in one cycle, loads/stores run a
// req/gnt/rvalid bus handshake. Optional macro MEM_MISALIGN_TRAP_EN traps misaligned H/W.
module mem_stage #(
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic                      wmem_en_i,
  input  logic                      rmem_en_i,
  input  logic [ADDR_WIDTH-1:0]     mem_addr_i,
  input  logic [2:0]                funct3_i,
  input  logic [31:0]               store_data_i,
  input  logic                      wreg_en_i,
  input  logic [REG_ADDR_WIDTH-1:0] wreg_addr_i,
  input  logic [31:0]               wreg_data_i,
  output logic                      dbus_req_o,
  output logic                      dbus_we_o,
  output logic [ADDR_WIDTH-1:0]     dbus_addr_o,
  output logic [3:0]                dbus_wstrb_o,
  output logic [31:0]               dbus_wdata_o,
  input  logic                      dbus_gnt_i,
  input  logic                      dbus_rvalid_i,
  input  logic [31:0]               dbus_rdata_i,
  output logic                      valid_o,
  output logic                      wreg_en_o,
  output logic [REG_ADDR_WIDTH-1:0] wreg_addr_o,
  output logic [31:0]               wreg_data_o,
  output logic                      misalign_o,
  output logic [1:0]                dbg_state_o
);

  // Handshake: an op transfers on a clock edge where valid_i && ready_o; ready_o is 1
  // only in IDLE, so valid_i is ignored while a bus access is in flight.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2} state_t;

  state_t                    r_state;
  logic [2:0]                r_f3;
  logic [1:0]                r_lo;
  logic                      r_is_store;
  logic                      r_wen;
  logic [REG_ADDR_WIDTH-1:0] r_waddr;

  logic        w_mem_op;
  logic        w_misalign;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  assign w_mem_op    = wmem_en_i | rmem_en_i;
  assign dbg_state_o = r_state;

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_misalign = ((funct3_i[1:0] == 2'b01) & mem_addr_i[0]) |
                      (funct3_i[1] & (mem_addr_i[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  always_comb begin
    w_wstrb = 4'b1111;
    w_wdata = store_data_i;
    case (funct3_i[1:0])
      2'b00: begin
        w_wstrb = 4'b0001 << mem_addr_i[1:0];
        w_wdata = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        w_wstrb = mem_addr_i[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{store_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Extraction uses the low address bits captured at issue, not the bus address.
  always_comb begin
    w_byte = dbus_rdata_i[7:0];
    case (r_lo)
      2'd1:    w_byte = dbus_rdata_i[15:8];
      2'd2:    w_byte = dbus_rdata_i[23:16];
      2'd3:    w_byte = dbus_rdata_i[31:24];
      default: ;
    endcase
    w_half      = r_lo[1] ? dbus_rdata_i[31:16] : dbus_rdata_i[15:0];
    w_load_data = dbus_rdata_i;
    case (r_f3[1:0])
      2'b00:   w_load_data = {{24{~r_f3[2] & w_byte[7]}}, w_byte};
      2'b01:   w_load_data = {{16{~r_f3[2] & w_half[15]}}, w_half};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_f3         <= '0;
      r_lo         <= '0;
      r_is_store   <= 1'b0;
      r_wen        <= 1'b0;
      r_waddr      <= '0;
      ready_o      <= 1'b1;
      dbus_req_o   <= 1'b0;
      dbus_we_o    <= 1'b0;
      dbus_addr_o  <= '0;
      dbus_wstrb_o <= '0;
      dbus_wdata_o <= '0;
      valid_o      <= 1'b0;
      wreg_en_o    <= 1'b0;
      wreg_addr_o  <= '0;
      wreg_data_o  <= '0;
      misalign_o   <= 1'b0;
    end else begin
      valid_o    <= 1'b0;
      misalign_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (valid_i) begin
            if (!w_mem_op) begin
              valid_o     <= 1'b1;
              wreg_en_o   <= wreg_en_i;
              wreg_addr_o <= wreg_addr_i;
              wreg_data_o <= wreg_data_i;
            end else if (w_misalign) begin
              valid_o     <= 1'b1;
              wreg_en_o   <= 1'b0;
              wreg_addr_o <= wreg_addr_i;
              misalign_o  <= 1'b1;
            end else begin
              r_f3         <= funct3_i;
              r_lo         <= mem_addr_i[1:0];
              r_is_store   <= wmem_en_i;
              r_wen        <= wreg_en_i;
              r_waddr      <= wreg_addr_i;
              dbus_req_o   <= 1'b1;
              dbus_we_o    <= wmem_en_i;
              dbus_addr_o  <= {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
              dbus_wstrb_o <= wmem_en_i ? w_wstrb : 4'b0000;
              dbus_wdata_o <= wmem_en_i ? w_wdata : 32'd0;
              ready_o      <= 1'b0;
              r_state      <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (dbus_gnt_i) begin
            dbus_req_o <= 1'b0;
            if (r_is_store) begin
              valid_o     <= 1'b1;
              wreg_en_o   <= 1'b0;
              wreg_addr_o <= r_waddr;
              ready_o     <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (dbus_rvalid_i) begin
            valid_o     <= 1'b1;
            wreg_en_o   <= r_wen;
            wreg_addr_o <= r_waddr;
            wreg_data_o <= w_load_data;
            ready_o     <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed cases plus randomized ops against a behavioural model;
// a bus driver responds with random gnt/rvalid delays. Honours MEM_MISALIGN_TRAP_EN.
module tb_mem_stage;

  localparam int EW = 39;  // {misalign, wreg_en, wreg_addr[4:0], wreg_data[31:0]}

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, ready_o, wmem_en_i, rmem_en_i;
  logic [31:0] mem_addr_i, store_data_i, wreg_data_i;
  logic [2:0]  funct3_i;
  logic        wreg_en_i;
  logic [4:0]  wreg_addr_i;
  logic        dbus_req_o, dbus_we_o, dbus_gnt_i, dbus_rvalid_i;
  logic [31:0] dbus_addr_o, dbus_wdata_o, dbus_rdata_i;
  logic [3:0]  dbus_wstrb_o;
  logic        valid_o, wreg_en_o, misalign_o;
  logic [4:0]  wreg_addr_o;
  logic [31:0] wreg_data_o;
  logic [1:0]  dbg_state_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [EW-1:0] exp_q[$];

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .wmem_en_i(wmem_en_i), .rmem_en_i(rmem_en_i), .mem_addr_i(mem_addr_i),
    .funct3_i(funct3_i), .store_data_i(store_data_i), .wreg_en_i(wreg_en_i),
    .wreg_addr_i(wreg_addr_i), .wreg_data_i(wreg_data_i),
    .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
    .dbus_wstrb_o(dbus_wstrb_o), .dbus_wdata_o(dbus_wdata_o),
    .dbus_gnt_i(dbus_gnt_i), .dbus_rvalid_i(dbus_rvalid_i), .dbus_rdata_i(dbus_rdata_i),
    .valid_o(valid_o), .wreg_en_o(wreg_en_o), .wreg_addr_o(wreg_addr_o),
    .wreg_data_o(wreg_data_o), .misalign_o(misalign_o), .dbg_state_o(dbg_state_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] f3,
                                             input logic [31:0] rdata);
    logic [31:0] b, h;
    b = (rdata >> (8 * int'(addr[1:0]))) & 32'hFF;
    h = (rdata >> (16 * int'(addr[1]))) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'd128)   ? (b | 32'hFFFF_FF00) : b;
      3'b001:  return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return rdata;
    endcase
  endfunction

  function automatic logic [3:0] model_wstrb(input logic [31:0] addr, input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 4'(1 << addr[1:0]);
    if (f3[1:0] == 2'b01) return addr[1] ? 4'd12 : 4'd3;
    return 4'd15;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3[1:0] == 2'b00) return (d & 32'hFF) * 32'h0101_0101;
    if (f3[1:0] == 2'b01) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic bit model_trap(input logic [31:0] addr, input logic [2:0] f3);
`ifdef MEM_MISALIGN_TRAP_EN
    if (f3[1:0] == 2'b01) return addr[0];
    if (f3[1:0] != 2'b00) return (addr % 4) != 0;
`endif
    return 1'b0;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_o) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL wb_unexpected: valid_o=1 with nothing expected at %0t", $time);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          if (e[37])
            chk("wb_entry", 64'({misalign_o, wreg_en_o, wreg_addr_o, wreg_data_o}), 64'(e));
          else
            chk("wb_flags", 64'({misalign_o, wreg_en_o}), 64'(e[38:37]));
        end
      end else begin
        chk("misalign_idle", 64'(misalign_o), 64'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic junk_inputs();
    valid_i      = 1'($urandom_range(0, 1));
    wmem_en_i    = 1'($urandom_range(0, 1));
    rmem_en_i    = 1'($urandom_range(0, 1));
    mem_addr_i   = $urandom;
    funct3_i     = 3'($urandom_range(0, 7));
    store_data_i = $urandom;
    wreg_en_i    = 1'($urandom_range(0, 1));
    wreg_addr_i  = 5'($urandom_range(0, 31));
    wreg_data_i  = $urandom;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, 64'(ready_o), 64'd1);
    chk({tag, "_zero"}, 64'({dbus_req_o, dbus_we_o, dbus_addr_o, dbus_wstrb_o, dbus_wdata_o,
                             valid_o, wreg_en_o, wreg_addr_o, wreg_data_o, misalign_o}), 64'd0);
    chk({tag, "_wide"}, 64'({dbus_wdata_o, wreg_data_o}), 64'd0);
  endtask

  // Issue one op (called at a negedge) and play the bus; abort=1 resets the DUT in WAIT.
  task automatic do_op(input logic st, input logic ld, input logic [31:0] addr,
                       input logic [2:0] f3, input logic [31:0] sdata, input logic wen,
                       input logic [4:0] waddr, input logic [31:0] wdata,
                       input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                       input bit abort);
    bit mem, trap;
    int k;
    k = 0;
    while (!ready_o && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!ready_o) begin
      chk("ready_timeout", 64'(ready_o), 64'd1);
      return;
    end
    mem  = st | ld;
    trap = mem && model_trap(addr, f3);
    valid_i = 1'b1; wmem_en_i = st; rmem_en_i = ld; mem_addr_i = addr; funct3_i = f3;
    store_data_i = sdata; wreg_en_i = wen; wreg_addr_i = waddr; wreg_data_i = wdata;
    if (!mem)      exp_q.push_back({1'b0, wen, waddr, wdata});
    else if (trap) exp_q.push_back({1'b1, 1'b0, waddr, 32'd0});
    else if (st)   exp_q.push_back({1'b0, 1'b0, waddr, 32'd0});
    else if (!abort) exp_q.push_back({1'b0, wen, waddr, model_load(addr, f3, rdata)});
    @(negedge clk);
    valid_i = 1'b0;
    if (!mem || trap) begin
      chk("pass_lat", 64'(valid_o), 64'd1);
      chk("pass_ready", 64'(ready_o), 64'd1);
      chk("pass_noreq", 64'(dbus_req_o), 64'd0);
      return;
    end
    chk("req_lat", 64'(dbus_req_o), 64'd1);
    for (int i = 0; i <= gnt_dly; i++) begin
      if (i == gnt_dly) begin
        valid_i = 1'b0;
        dbus_gnt_i = 1'b1;
      end else begin
        junk_inputs();
      end
      dbus_rvalid_i = 1'($urandom_range(0, 1));
      dbus_rdata_i  = $urandom;
      chk("req_hold", 64'(dbus_req_o), 64'd1);
      chk("req_ready", 64'(ready_o), 64'd0);
      chk("bus_addr", 64'(dbus_addr_o), 64'(addr & 32'hFFFF_FFFC));
      chk("bus_we", 64'(dbus_we_o), 64'(st));
      if (st) begin
        chk("bus_wstrb", 64'(dbus_wstrb_o), 64'(model_wstrb(addr, f3)));
        chk("bus_wdata", 64'(dbus_wdata_o), 64'(model_wdata(f3, sdata)));
      end
      @(negedge clk);
    end
    dbus_gnt_i = 1'b0;
    dbus_rvalid_i = 1'b0;
    if (st) begin
      chk("st_lat", 64'(valid_o), 64'd1);
      chk("st_ready", 64'(ready_o), 64'd1);
      return;
    end
    chk("ld_req_drop", 64'(dbus_req_o), 64'd0);
    for (int i = 0; i < rv_dly; i++) begin
      junk_inputs();
      chk("wait_ready", 64'(ready_o), 64'd0);
      @(negedge clk);
    end
    valid_i = 1'b0;
    if (abort) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset_vals("abort");
      dbus_rvalid_i = 1'b1;
      dbus_rdata_i  = rdata;
      @(negedge clk);
      dbus_rvalid_i = 1'b0;
      chk("abort_novalid", 64'(valid_o), 64'd0);
      chk("abort_ready", 64'(ready_o), 64'd1);
      return;
    end
    chk("wait_ready_last", 64'(ready_o), 64'd0);
    dbus_rvalid_i = 1'b1;
    dbus_rdata_i  = rdata;
    @(negedge clk);
    dbus_rvalid_i = 1'b0;
    dbus_rdata_i  = $urandom;
    chk("ld_lat", 64'(valid_o), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] f3_tab [6];
    f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011};
    rst = 1'b1;
    valid_i = 1'b0; wmem_en_i = 1'b0; rmem_en_i = 1'b0; mem_addr_i = '0; funct3_i = '0;
    store_data_i = '0; wreg_en_i = 1'b0; wreg_addr_i = '0; wreg_data_i = '0;
    dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0; dbus_rdata_i = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rst = 1'b0;

    // model pins
    chk("model_lb", 64'(model_load(32'h2, 3'b000, 32'h0080_0000)), 64'hFFFF_FF80);
    chk("model_lhu", 64'(model_load(32'h2, 3'b101, 32'h8001_0000)), 64'h0000_8001);
    chk("model_sb_strb", 64'(model_wstrb(32'h103, 3'b000)), 64'h8);
    chk("model_sb_data", 64'(model_wdata(3'b000, 32'hAABB_CCDD)), 64'hDDDD_DDDD);
    chk("model_sh_strb", 64'(model_wstrb(32'h2, 3'b001)), 64'hC);

    // directed
    do_op(0, 0, 32'h0, 3'b000, 32'h0, 1, 5'd5, 32'h1234, 0, 0, 32'h0, 0);
    do_op(1, 0, 32'h103, 3'b000, 32'hAABB_CCDD, 1, 5'd3, 32'h0, 2, 0, 32'h0, 0);
    do_op(0, 1, 32'h2, 3'b000, 32'h0, 1, 5'd7, 32'h0, 0, 0, 32'h0080_0000, 0);
    do_op(0, 1, 32'h2, 3'b101, 32'h0, 1, 5'd8, 32'h0, 1, 1, 32'h8001_0000, 0);
    do_op(0, 1, 32'h40, 3'b010, 32'h0, 1, 5'd9, 32'h0, 0, 5, 32'hCAFE_F00D, 0);
    do_op(0, 1, 32'h44, 3'b010, 32'h0, 1, 5'd10, 32'h0, 1, 2, 32'h1111_2222, 1);
    do_op(0, 1, 32'h101, 3'b010, 32'h0, 1, 5'd11, 32'h0, 0, 0, 32'h89AB_CDEF, 0);
    do_op(1, 1, 32'h202, 3'b001, 32'h1234_5678, 1, 5'd12, 32'h0, 0, 0, 32'h0, 0);
    do_op(0, 0, 32'h0, 3'b000, 32'h0, 0, 5'd13, 32'h5555, 0, 0, 32'h0, 0);

    // randomized
    for (int n = 0; n < 300; n++) begin
      int kind;
      kind = $urandom_range(0, 3);
      do_op(1'(kind[1]), 1'(kind[0]), $urandom, f3_tab[$urandom_range(0, 5)], $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 0);
    end

    valid_i = 1'b0;
    repeat (5) @(negedge clk);
    chk("drain", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
